// File: rtl/audio_pkg.sv
// Shared I2S framing constants and saturation limits for the PSG audio output stage.
package audio_pkg;

    localparam int I2S_SLOT_BITS   = 32;
    localparam int I2S_FRAME_BCLKS = 64;

    function automatic logic signed [63:0] sat_max(input int bits);
        return (64'sd1 <<< (bits - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bits);
        return -(64'sd1 <<< (bits - 1));
    endfunction

endpackage

// File: rtl/audio_sat.sv
// Combinational sample conditioning: arithmetic shift, saturate to the DAC word range, mute.
module audio_sat
    import audio_pkg::*;
#(
    parameter int IN_WIDTH    = 23,
    parameter int SHIFT       = 7,
    parameter int SAMPLE_BITS = 16
)
(
    input  logic signed [IN_WIDTH-1:0]    i_sample,
    input  logic                          i_mute,
    output logic        [SAMPLE_BITS-1:0] o_word
);

    localparam logic signed [63:0] MAX_V = sat_max(SAMPLE_BITS);
    localparam logic signed [63:0] MIN_V = sat_min(SAMPLE_BITS);

    logic signed [63:0] w_wide;
    logic signed [63:0] w_shifted;

    // Widen first so the limit compare works for any IN_WIDTH/SAMPLE_BITS pairing.
    assign w_wide    = {{(64 - IN_WIDTH){i_sample[IN_WIDTH-1]}}, i_sample};
    assign w_shifted = w_wide >>> SHIFT;

    always_comb begin
        o_word = '0;
        if (i_mute) begin
            o_word = '0;
        end else if (w_shifted > MAX_V) begin
            o_word = MAX_V[SAMPLE_BITS-1:0];
        end else if (w_shifted < MIN_V) begin
            o_word = MIN_V[SAMPLE_BITS-1:0];
        end else begin
            o_word = w_shifted[SAMPLE_BITS-1:0];
        end
    end

endmodule

// File: rtl/audio_i2s_out.sv
// I2S master for the PSG audio path: bclk divider, 64-bclk frame counter, per-frame
// sample latch with next_sample strobe, and MSB-first left-justified serialisation.
module audio_i2s_out
    import audio_pkg::*;
#(
    parameter int BCLK_DIV    = 4,
    parameter int IN_WIDTH    = 23,
    parameter int SHIFT       = 7,
    parameter int SAMPLE_BITS = 16
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_WIDTH-1:0] left_in,
    input  logic signed [IN_WIDTH-1:0] right_in,
    input  logic                       mute,
    output logic                       next_sample,
    output logic                       i2s_bclk,
    output logic                       i2s_lrck,
    output logic                       i2s_data
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam int               PAD      = I2S_SLOT_BITS - SAMPLE_BITS;

    logic [DIV_W-1:0]         r_div_cnt;
    logic [5:0]               r_bit_cnt;
    logic [SAMPLE_BITS-1:0]   r_left_word;
    logic [SAMPLE_BITS-1:0]   r_right_word;

    logic [SAMPLE_BITS-1:0]   w_left_word;
    logic [SAMPLE_BITS-1:0]   w_right_word;
    logic                     w_tc;
    logic                     w_fall;
    logic [5:0]               w_bit_nxt;
    logic                     w_lrck_nxt;
    logic [I2S_SLOT_BITS-1:0] w_left_slot;
    logic [I2S_SLOT_BITS-1:0] w_right_slot;
    logic [4:0]               w_slot_pos;
    logic                     w_data_nxt;

    audio_sat #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .SAMPLE_BITS(SAMPLE_BITS)) u_sat_left (
        .i_sample (left_in),
        .i_mute   (mute),
        .o_word   (w_left_word)
    );

    audio_sat #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .SAMPLE_BITS(SAMPLE_BITS)) u_sat_right (
        .i_sample (right_in),
        .i_mute   (mute),
        .o_word   (w_right_word)
    );

    assign w_tc      = (r_div_cnt == DIV_LAST);
    assign w_fall    = w_tc && i2s_bclk;
    assign w_bit_nxt = r_bit_cnt + 6'd1;

    // lrck follows (new_count + 1), i.e. current count + 2, one slot-bit ahead of the data.
    assign w_lrck_nxt = (6'(r_bit_cnt + 6'd2) >= 6'd32);

    // The bit being emitted is slot position new_count - 1, which is the current count;
    // slots are left-justified so positions past the word read the zero padding.
    assign w_left_slot  = 32'(r_left_word) << PAD;
    assign w_right_slot = 32'(r_right_word) << PAD;
    assign w_slot_pos   = ~r_bit_cnt[4:0];
    assign w_data_nxt   = r_bit_cnt[5] ? w_right_slot[w_slot_pos] : w_left_slot[w_slot_pos];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= 6'd63;
            r_left_word  <= '0;
            r_right_word <= '0;
            next_sample  <= 1'b0;
            i2s_bclk     <= 1'b0;
            i2s_lrck     <= 1'b0;
            i2s_data     <= 1'b0;
        end else begin
            next_sample <= 1'b0;
            if (w_tc) begin
                r_div_cnt <= '0;
                i2s_bclk  <= ~i2s_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_ONE;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                i2s_lrck  <= w_lrck_nxt;
                i2s_data  <= w_data_nxt;
                if (w_bit_nxt == 6'd0) begin
                    r_left_word  <= w_left_word;
                    r_right_word <= w_right_word;
                    next_sample  <= 1'b1;
                end
            end
        end
    end

endmodule
